// File: rtl/gpio_sw_debounce.sv
// Per-bit synchroniser and debouncer for raw slide-switch pins, with optional
// edge pulses, sticky pending flags and irq (enabled by GPIO_SW_DEBOUNCE_IRQ_EN).
module gpio_sw_debounce #(
  parameter int WIDTH           = 16,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] sw_i,
  output logic [WIDTH-1:0] sw_o,
  output logic [WIDTH-1:0] rise_o,
  output logic [WIDTH-1:0] fall_o,
  output logic [WIDTH-1:0] pend_o,
  input  logic [WIDTH-1:0] irq_clr_i,
  input  logic [WIDTH-1:0] irq_mask_i,
  output logic             irq_o
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] sync;
  logic [CW-1:0]    cnt_q  [WIDTH];
  logic [CW-1:0]    cnt_d  [WIDTH];
  logic [WIDTH-1:0] sw_q, sw_d;
  logic [WIDTH-1:0] upd;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
    end else begin
      sync_q[0] <= sw_i;
      for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
    end
  end

  assign sync = sync_q[SYNC_STAGES-1];

  // A disagreement must persist DEBOUNCE_CYCLES cycles; any agreement restarts it.
  always_comb begin
    sw_d = sw_q;
    upd  = '0;
    for (int i = 0; i < WIDTH; i++) begin
      cnt_d[i] = '0;
      if (sync[i] != sw_q[i]) begin
        if (cnt_q[i] != CNT_LAST) begin
          cnt_d[i] = cnt_q[i] + CW'(1);
        end else begin
          sw_d[i] = sync[i];
          upd[i]  = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sw_q <= '0;
      for (int i = 0; i < WIDTH; i++) cnt_q[i] <= '0;
    end else begin
      sw_q <= sw_d;
      for (int i = 0; i < WIDTH; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign sw_o = sw_q;

`ifdef GPIO_SW_DEBOUNCE_IRQ_EN
  logic [WIDTH-1:0] rise_q, fall_q, pend_q;
  logic [WIDTH-1:0] rise_d, fall_d, pend_d;

  assign rise_d = upd & sync;
  assign fall_d = upd & ~sync;
  // Pending is set from the registered pulse, so a clear in the pulse cycle loses.
  assign pend_d = rise_q | fall_q | (pend_q & ~irq_clr_i);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rise_q <= '0;
      fall_q <= '0;
      pend_q <= '0;
    end else begin
      rise_q <= rise_d;
      fall_q <= fall_d;
      pend_q <= pend_d;
    end
  end

  assign rise_o = rise_q;
  assign fall_o = fall_q;
  assign pend_o = pend_q;
  assign irq_o  = |(pend_q & ~irq_mask_i);
`else
  logic unused_irq_in;
  assign unused_irq_in = ^{irq_clr_i, irq_mask_i, upd};

  assign rise_o = '0;
  assign fall_o = '0;
  assign pend_o = '0;
  assign irq_o  = 1'b0;
`endif

endmodule

// File: tb/tb_gpio_sw_debounce.sv
// Directed bench for gpio_sw_debounce (WIDTH=16, SYNC_STAGES=2, DEBOUNCE_CYCLES=4).
module tb_gpio_sw_debounce;

`ifdef GPIO_SW_DEBOUNCE_IRQ_EN
  localparam bit IRQ = 1'b1;
`else
  localparam bit IRQ = 1'b0;
`endif

  typedef struct {
    logic [15:0] sw;
    logic [15:0] clr;
    logic [15:0] mask;
    logic [15:0] e_sw;
    logic [15:0] e_rise;
    logic [15:0] e_fall;
    logic [15:0] e_pend;
    logic        e_irq;
  } vec_t;

  logic        clk;
  logic        reset_n;
  logic [15:0] sw_i, sw_o, rise_o, fall_o, pend_o, irq_clr_i, irq_mask_i;
  logic        irq_o;

  int checks   = 0;
  int failures = 0;
  vec_t vecs[$];

  gpio_sw_debounce #(
    .WIDTH(16), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4)
  ) dut (
    .clk(clk), .reset_n(reset_n), .sw_i(sw_i), .sw_o(sw_o),
    .rise_o(rise_o), .fall_o(fall_o), .pend_o(pend_o),
    .irq_clr_i(irq_clr_i), .irq_mask_i(irq_mask_i), .irq_o(irq_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [15:0] g(input logic [15:0] v);
    return IRQ ? v : 16'h0000;
  endfunction

  task automatic chk(input string name, input int idx, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s @%0d: got %h want %h", name, idx, act, exp);
    end
  endtask

  task automatic chk_all(input int idx, input logic [15:0] esw, input logic [15:0] er,
                         input logic [15:0] ef, input logic [15:0] ep, input logic ei);
    chk("sw_o",   idx, sw_o,   esw);
    chk("rise_o", idx, rise_o, g(er));
    chk("fall_o", idx, fall_o, g(ef));
    chk("pend_o", idx, pend_o, g(ep));
    chk("irq_o",  idx, {15'd0, irq_o}, {15'd0, ei & IRQ});
  endtask

  task automatic add(input logic [15:0] s, input logic [15:0] c, input logic [15:0] m,
                     input logic [15:0] esw, input logic [15:0] er, input logic [15:0] ef,
                     input logic [15:0] ep, input logic ei);
    vec_t v;
    v.sw = s; v.clr = c; v.mask = m;
    v.e_sw = esw; v.e_rise = er; v.e_fall = ef; v.e_pend = ep; v.e_irq = ei;
    vecs.push_back(v);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // all-high through reset, then release, fall, clear, mask
    for (int k = 0; k < 5; k++) add(16'hFFFF, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 1'b0);
    add(16'hFFFF, 16'h0,    16'h0, 16'hFFFF, 16'hFFFF, 16'h0, 16'h0,    1'b0);
    add(16'hFFFF, 16'h0,    16'h0, 16'hFFFF, 16'h0,    16'h0, 16'hFFFF, 1'b1);
    add(16'hFFFF, 16'hFFFF, 16'h0, 16'hFFFF, 16'h0,    16'h0, 16'h0,    1'b0);
    for (int k = 0; k < 5; k++) add(16'h0, 16'h0, 16'h0, 16'hFFFF, 16'h0, 16'h0, 16'h0, 1'b0);
    add(16'h0, 16'h0,    16'h0,    16'h0, 16'h0, 16'hFFFF, 16'h0,    1'b0);
    add(16'h0, 16'h0,    16'h0,    16'h0, 16'h0, 16'h0,    16'hFFFF, 1'b1);
    add(16'h0, 16'h0,    16'hFFFF, 16'h0, 16'h0, 16'h0,    16'hFFFF, 1'b0);
    add(16'h0, 16'hFFFF, 16'h0,    16'h0, 16'h0, 16'h0,    16'h0,    1'b0);
    // bit 3 rise then fall
    for (int k = 0; k < 5; k++) add(16'h0008, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 1'b0);
    add(16'h0008, 16'h0, 16'h0, 16'h0008, 16'h0008, 16'h0, 16'h0,    1'b0);
    add(16'h0008, 16'h0, 16'h0, 16'h0008, 16'h0,    16'h0, 16'h0008, 1'b1);
    for (int k = 0; k < 5; k++) add(16'h0, 16'h0, 16'h0, 16'h0008, 16'h0, 16'h0, 16'h0008, 1'b1);
    add(16'h0, 16'h0,    16'h0, 16'h0, 16'h0, 16'h0008, 16'h0008, 1'b1);
    add(16'h0, 16'h0,    16'h0, 16'h0, 16'h0, 16'h0,    16'h0008, 1'b1);
    add(16'h0, 16'h0008, 16'h0, 16'h0, 16'h0, 16'h0,    16'h0,    1'b0);
    // bit 5: 3-cycle glitch rejected, then a held level accepted
    for (int k = 0; k < 3; k++) add(16'h0020, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 1'b0);
    for (int k = 0; k < 5; k++) add(16'h0,    16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 1'b0);
    for (int k = 0; k < 5; k++) add(16'h0020, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 1'b0);
    add(16'h0020, 16'h0,    16'h0, 16'h0020, 16'h0020, 16'h0, 16'h0,    1'b0);
    add(16'h0020, 16'h0,    16'h0, 16'h0020, 16'h0,    16'h0, 16'h0020, 1'b1);
    add(16'h0020, 16'h0020, 16'h0, 16'h0020, 16'h0,    16'h0, 16'h0,    1'b0);

    reset_n = 1'b0; sw_i = 16'hFFFF; irq_clr_i = '0; irq_mask_i = '0;
    #2;
    chk_all(-1, 16'h0, 16'h0, 16'h0, 16'h0, 1'b0);
    repeat (3) step();
    chk_all(0, 16'h0, 16'h0, 16'h0, 16'h0, 1'b0);
    reset_n = 1'b1;

    foreach (vecs[i]) begin
      sw_i = vecs[i].sw; irq_clr_i = vecs[i].clr; irq_mask_i = vecs[i].mask;
      step();
      chk_all(i + 1, vecs[i].e_sw, vecs[i].e_rise, vecs[i].e_fall, vecs[i].e_pend, vecs[i].e_irq);
    end
    irq_clr_i = '0; irq_mask_i = '0;

    // mask, unmask within a cycle, clear
    irq_mask_i = 16'h0008; sw_i = 16'h0028;
    repeat (6) step();
    chk_all(1000, 16'h0028, 16'h0008, 16'h0, 16'h0, 1'b0);
    step();
    chk_all(1001, 16'h0028, 16'h0, 16'h0, 16'h0008, 1'b0);
    irq_mask_i = 16'h0;
    #1;
    chk("irq_unmask", 1002, {15'd0, irq_o}, {15'd0, IRQ});
    irq_clr_i = 16'h0008;
    step();
    irq_clr_i = 16'h0;
    chk_all(1003, 16'h0028, 16'h0, 16'h0, 16'h0, 1'b0);

    // fall on bit 3, clear, then clear collides with the next rise pulse
    sw_i = 16'h0020;
    repeat (7) step();
    chk_all(1004, 16'h0020, 16'h0, 16'h0, 16'h0008, 1'b1);
    irq_clr_i = 16'h0008;
    step();
    irq_clr_i = 16'h0;
    chk("pend_clr", 1005, pend_o, 16'h0);
    sw_i = 16'h0028;
    repeat (6) step();
    chk_all(1006, 16'h0028, 16'h0008, 16'h0, 16'h0, 1'b0);
    irq_clr_i = 16'h0008;
    step();
    irq_clr_i = 16'h0;
    chk("pend_set_wins", 1007, pend_o, g(16'h0008));
    step();
    chk_all(1008, 16'h0028, 16'h0, 16'h0, 16'h0008, 1'b1);

    // reset while bit 7 is mid-count
    sw_i = 16'h00A8;
    repeat (4) step();
    chk("sw_midcount", 1009, sw_o, 16'h0028);
    reset_n = 1'b0;
    #2;
    chk_all(1010, 16'h0, 16'h0, 16'h0, 16'h0, 1'b0);
    #1;
    reset_n = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      step();
      chk("sw_after_rst", 1010 + k, sw_o, 16'h0);
    end
    step();
    chk_all(1016, 16'h00A8, 16'h00A8, 16'h0, 16'h0, 1'b0);
    step();
    chk_all(1017, 16'h00A8, 16'h0, 16'h0, 16'h00A8, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/gpio_sw_debounce.md
# gpio_sw_debounce

Input-conditioning stage that sits directly upstream of the SoC GPIO input half on the FPGA board: it takes the raw, asynchronous slide-switch pins, synchronises and debounces each bit, and presents clean levels to the GPIO inputs (`io_data[31:16]`). Optionally it also detects edges on the debounced levels and raises a maskable, sticky interrupt toward the core.

## Interface
Parameters:
- `WIDTH`, 16, number of switch bits conditioned.
- `SYNC_STAGES`, 2, flip-flops in each bit's synchroniser chain (≥2).
- `DEBOUNCE_CYCLES`, 500000, consecutive stable `clk` cycles required to accept a new level (≥1; 10 ms at the 50 MHz core clock).

Ports:
- `clk` in 1: core clock, the divided board clock.
- `reset_n` in 1: reset, asynchronous assert, active-low.
- `sw_i` in `WIDTH`: raw switch pins, asynchronous to `clk`.
- `sw_o` out `WIDTH`: debounced level, registered.
- `rise_o` out `WIDTH`: one-cycle pulse on a 0→1 transition of `sw_o`.
- `fall_o` out `WIDTH`: one-cycle pulse on a 1→0 transition of `sw_o`.
- `pend_o` out `WIDTH`: sticky edge-pending flags.
- `irq_clr_i` in `WIDTH`: write-1-to-clear for `pend_o`, sampled every cycle.
- `irq_mask_i` in `WIDTH`: 1 = bit masked from `irq_o`.
- `irq_o` out 1: OR of unmasked pending flags.

## Operation
- Per bit: synchroniser chain → `sync`; counter `cnt` with width `$clog2(DEBOUNCE_CYCLES)` (minimum 1 bit); stable register `sw_o`.
- `sync == sw_o`: `cnt <= 0`.
- `sync != sw_o` and `cnt != DEBOUNCE_CYCLES-1`: `cnt <= cnt+1`.
- `sync != sw_o` and `cnt == DEBOUNCE_CYCLES-1`: `sw_o <= sync`, `cnt <= 0`. The matching `rise_o`/`fall_o` bit is 1 in the same cycle that `sw_o` takes its new value, and 0 otherwise.
- A disagreement lasting fewer than `DEBOUNCE_CYCLES` cycles at `sync` is discarded, and `cnt` restarts from 0 on the next disagreement. `cnt` never wraps.
- Pending, per bit: set on any `rise_o | fall_o`; cleared by `irq_clr_i` otherwise. A simultaneous set and clear leaves the bit set.
- `irq_o = |(pend_o & ~irq_mask_i)`, combinational from registers and the mask input.
- Bits are fully independent; any number of bits may change in the same cycle.

## Timing
- Reset values, all asynchronous to 0: synchroniser flops, `cnt`, `sw_o`, `rise_o`, `fall_o`, `pend_o`, `irq_o`.
- Latency from a `sw_i` change held stable to `sw_o` updating: exactly `SYNC_STAGES + DEBOUNCE_CYCLES` rising edges. The first `sync` mismatch appears after edge `SYNC_STAGES`, and `sw_o` updates on edge `SYNC_STAGES+DEBOUNCE_CYCLES`.
- A switch that is high through reset release is treated as a real edge. It produces a `rise_o` pulse and sets pending `SYNC_STAGES+DEBOUNCE_CYCLES` cycles after release. Software clears it at boot.
- `irq_clr_i` takes effect on the next edge. `irq_o` follows `irq_mask_i` changes within the same cycle.
- Reset mid-count discards all progress; nothing is retained across reset.

## Configuration
- Macro `GPIO_SW_DEBOUNCE_IRQ_EN`.
- Defined: edge detection, pending flags, and `irq_o` are built as described above.
- Undefined: `rise_o`, `fall_o`, `pend_o`, and `irq_o` are tied to 0, and `irq_clr_i`/`irq_mask_i` are ignored. Ports remain present. Synchroniser and debounce behaviour is identical.

## Test plan
Bench parameters: `WIDTH=16`, `SYNC_STAGES=2`, `DEBOUNCE_CYCLES=4`, macro defined unless noted.
1. `sw_i=16'hFFFF` held through reset → all outputs 0 during reset. After release, `sw_o=16'hFFFF` on edge 6, `rise_o=16'hFFFF` for that one cycle only, then `pend_o=16'hFFFF` and `irq_o=1`.
2. After a quiet state, `sw_i[3]` 0→1 held → `sw_o[3]=1` on edge 6 after the change, with `rise_o[3]` high for exactly that cycle. Later 1→0 → `fall_o[3]` single pulse, also with latency 6.
3. `sw_i[5]` high for 3 cycles then low → `sw_o[5]` stays 0, no pulses, `pend_o[5]=0`. Then high for 5 cycles → `sw_o[5]` rises.
4. `pend_o[3]=1` with `irq_mask_i[3]=1` → `irq_o=0`. Set `irq_mask_i[3]=0` → `irq_o=1` in the same cycle. Pulse `irq_clr_i[3]` → `pend_o[3]=0` next cycle. Assert `irq_clr_i[3]` in the exact cycle of a new `rise_o[3]` → `pend_o[3]` remains 1.
5. Drop `reset_n` while bit 7's `cnt=2` → `sw_o`, `cnt`, and `pend_o` clear immediately, with no clock required. After release, the held input needs the full 6 cycles again.
6. Macro undefined, step `sw_i[0]` → `sw_o[0]` updates at latency 6, while `rise_o`, `pend_o`, and `irq_o` stay 0 throughout.
